// File: rtl/conv_sched_if.sv
// conv_sched_if: bundles the control-side signals of the convolution window scheduler.
//   slave modport  : the scheduler (conv_sched) side.
//   master modport : the controller / testbench side.
// Signals:
//   start, img_w, img_h          : layer-pass request and image dimensions.
//   src_valid                    : line buffer has a window ready.
//   res_en                       : datapath result strobe (its en_out).
//   credit_ret                   : downstream buffer popped one entry.
//   win_en, win_row, win_col     : window issue strobe and top-left position.
//   busy, done, err              : pass status; done and err are one-cycle pulses.
//   stall_cnt                    : RUN cycles without an issue.
interface conv_sched_if #(
  parameter int unsigned DIM_W = 8
) ();
  logic             start;
  logic [DIM_W-1:0] img_w;
  logic [DIM_W-1:0] img_h;
  logic             src_valid;
  logic             res_en;
  logic             credit_ret;
  logic             win_en;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      stall_cnt;

  modport slave (
    input  start, img_w, img_h, src_valid, res_en, credit_ret,
    output win_en, win_row, win_col, busy, done, err, stall_cnt
  );

  modport master (
    output start, img_w, img_h, src_valid, res_en, credit_ret,
    input  win_en, win_row, win_col, busy, done, err, stall_cnt
  );
endinterface

// File: rtl/conv_sched.sv
// conv_sched: issues convolution windows in raster order to a KERNELxKERNEL MAC datapath,
// throttled by downstream buffer credits, and counts returning results to detect pass end.
// Ports:
//   clk  : clock, rising edge.
//   rst  : synchronous active-high reset.
//   bus  : conv_sched_if.slave (start/dims/src_valid/res_en/credit_ret in;
//          win_en/win_row/win_col/busy/done/err/stall_cnt out).
// Parameters: KERNEL (square kernel size), DIM_W (dimension width), CREDITS (buffer depth).
// Optional feature: define CONV_SCHED_STALL_CNT_EN to build the stall cycle counter;
// otherwise stall_cnt is tied to zero.
module conv_sched #(
  parameter int unsigned KERNEL  = 3,
  parameter int unsigned DIM_W   = 8,
  parameter int unsigned CREDITS = 4
) (
  input logic        clk,
  input logic        rst,
  conv_sched_if.slave bus
);
  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam int unsigned TW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] KDim    = DIM_W'(KERNEL);
  localparam logic [CW-1:0]    CredMax = CW'(CREDITS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [DIM_W-1:0] row_q, col_q;
  logic [DIM_W-1:0] lim_row_q, lim_col_q;  // last valid window position per axis
  logic [TW-1:0]    total_q, res_cnt_q;
  logic [CW-1:0]    credit_q;
  logic             busy_q, done_q, err_q;

  logic             win_en;
  logic             cfg_ok, accept, res_hit, cred_inc, last_win;
  logic [TW-1:0]    span_w, span_h, total_nx, res_cnt_nx;

  always_comb begin
    win_en     = (state_q == StRun) && bus.src_valid && (credit_q != '0);
    cfg_ok     = (bus.img_w >= KDim) && (bus.img_h >= KDim);
    accept     = (state_q == StIdle) && bus.start && cfg_ok;
    // Results outside a pass belong to an abandoned pass and are dropped.
    res_hit    = bus.res_en && ((state_q == StRun) || (state_q == StDrain));
    res_cnt_nx = res_cnt_q + TW'(res_hit);
    // A return while already full cannot correspond to a real pop.
    cred_inc   = bus.credit_ret && (credit_q != CredMax);
    last_win   = (row_q == lim_row_q) && (col_q == lim_col_q);
    span_w     = TW'(bus.img_w - KDim) + TW'(1);
    span_h     = TW'(bus.img_h - KDim) + TW'(1);
    total_nx   = span_w * span_h;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      col_q     <= '0;
      lim_row_q <= '0;
      lim_col_q <= '0;
      total_q   <= '0;
      res_cnt_q <= '0;
      credit_q  <= CredMax;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // Issue and return in the same cycle cancel out.
      if (win_en && !cred_inc) begin
        credit_q <= credit_q - 1'b1;
      end else if (!win_en && cred_inc) begin
        credit_q <= credit_q + 1'b1;
      end

      if (res_hit) begin
        res_cnt_q <= res_cnt_nx;
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            lim_col_q <= bus.img_w - KDim;
            lim_row_q <= bus.img_h - KDim;
            total_q   <= total_nx;
            row_q     <= '0;
            col_q     <= '0;
            res_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StRun;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        StRun: begin
          if (win_en) begin
            if (last_win) begin
              state_q <= StDrain;
            end else if (col_q == lim_col_q) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: begin
          // Uses the post-increment count so a final result landing now is not missed.
          if (res_cnt_nx == total_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef CONV_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((state_q == StRun) && !win_en && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

  assign bus.win_en  = win_en;
  assign bus.win_row = row_q;
  assign bus.win_col = col_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
